// File: rtl/exe_stage_muldiv_pkg.sv
// Shared definitions for the execute stage: datapath widths, EXE_CMD encodings
// and the IDLE/BUSY state constants of the multi-cycle sequencer.
package exe_stage_muldiv_pkg;

    localparam int WORD_LEN_DEF     = 32;
    localparam int REG_ADDR_LEN_DEF = 5;

    localparam logic [3:0] EXE_ADD = 4'd0;
    localparam logic [3:0] EXE_SUB = 4'd1;
    localparam logic [3:0] EXE_AND = 4'd2;
    localparam logic [3:0] EXE_OR  = 4'd3;
    localparam logic [3:0] EXE_NOR = 4'd4;
    localparam logic [3:0] EXE_XOR = 4'd5;
    localparam logic [3:0] EXE_SLL = 4'd6;
    localparam logic [3:0] EXE_SRL = 4'd7;
    localparam logic [3:0] EXE_SRA = 4'd8;
    localparam logic [3:0] EXE_MUL = 4'd9;
    localparam logic [3:0] EXE_DIV = 4'd10;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

endpackage

// File: rtl/exe_stage_muldiv_iter.sv
// Iterative engine: one shift-add (MUL, low word of unsigned product) or one
// restoring-divide step (DIV, unsigned quotient) per clock, W steps per op.
module exe_stage_muldiv_iter
    import exe_stage_muldiv_pkg::*;
#(
    parameter int W = WORD_LEN_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         abort,
    input  logic         start,
    input  logic         op,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] result
);
    localparam int CW = $clog2(W);

    logic [CW-1:0] cnt;
    logic          op_div;
    // acc: product accumulator / partial remainder; sh_a: multiplicand / dividend-quotient; sh_b: multiplier / divisor
    logic [W-1:0]  acc;
    logic [W-1:0]  sh_a;
    logic [W-1:0]  sh_b;

    logic [W-1:0]  mul_acc_nx;
    logic [W:0]    rem_sh;
    logic          q_bit;
    logic [W-1:0]  rem_nx;
    logic [W-1:0]  quo_nx;

    always_comb begin
        mul_acc_nx = acc + (sh_b[0] ? sh_a : '0);
        rem_sh     = {acc, sh_a[W-1]};
        q_bit      = (rem_sh >= {1'b0, sh_b});
        rem_nx     = q_bit ? W'(rem_sh - {1'b0, sh_b}) : rem_sh[W-1:0];
        quo_nx     = {sh_a[W-2:0], q_bit};
    end

    // The final step's value is presented combinationally so the caller can register it on the done edge.
    assign done   = busy && (cnt == CW'(W - 1));
    assign result = op_div ? quo_nx : mul_acc_nx;

    always_ff @(posedge clk) begin
        if (rst || abort) begin
            busy <= 1'b0;
            cnt  <= '0;
        end else if (start) begin
            busy <= 1'b1;
            cnt  <= '0;
        end else if (busy) begin
            cnt <= cnt + 1'b1;
            if (done) begin
                busy <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (start && !busy) begin
            op_div <= op;
            acc    <= '0;
            sh_a   <= a;
            sh_b   <= b;
        end else if (busy) begin
            if (op_div) begin
                acc  <= rem_nx;
                sh_a <= quo_nx;
            end else begin
                acc  <= mul_acc_nx;
                sh_a <= sh_a << 1;
                sh_b <= sh_b >> 1;
            end
        end
    end

endmodule

// File: rtl/exe_stage_muldiv.sv
// Execute stage with EXE/MEM register: single-cycle ALU plus an iterative
// MUL/DIV engine that stalls upstream until its result is registered.
module exe_stage_muldiv
    import exe_stage_muldiv_pkg::*;
#(
    parameter int WORD_LEN     = WORD_LEN_DEF,
    parameter int REG_ADDR_LEN = REG_ADDR_LEN_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic                    in_valid,
    input  logic [3:0]              EXE_CMD,
    input  logic [WORD_LEN-1:0]     val1,
    input  logic [WORD_LEN-1:0]     val2,
    input  logic [WORD_LEN-1:0]     ST_val_in,
    input  logic [REG_ADDR_LEN-1:0] dest_in,
    input  logic                    MEM_R_EN_in,
    input  logic                    MEM_W_EN_in,
    input  logic                    WB_EN_in,
    output logic                    stall,
    output logic                    out_valid,
    output logic [WORD_LEN-1:0]     ALU_res,
    output logic [WORD_LEN-1:0]     ST_value,
    output logic [REG_ADDR_LEN-1:0] dest,
    output logic                    MEM_R_EN,
    output logic                    MEM_W_EN,
    output logic                    WB_EN
);
    logic [0:0]                 state;
    logic                       accept;
    logic                       is_multi;
    logic                       eng_start;
    logic                       eng_busy;
    logic                       eng_done;
    logic [WORD_LEN-1:0]        eng_result;
    logic [WORD_LEN-1:0]        alu_out;
    logic signed [WORD_LEN-1:0] val1_s;
    logic [4:0]                 shamt;

    logic [WORD_LEN-1:0]        hold_st;
    logic [REG_ADDR_LEN-1:0]    hold_dest;
    logic                       hold_mem_r;
    logic                       hold_mem_w;
    logic                       hold_wb;

    assign stall     = (state == ST_BUSY);
    assign accept    = in_valid && (state == ST_IDLE) && !flush;
    // Divide by zero stays single-cycle so the engine never sees a zero divisor.
    assign is_multi  = (EXE_CMD == EXE_MUL) || ((EXE_CMD == EXE_DIV) && (val2 != '0));
    assign eng_start = accept && is_multi;
    assign val1_s    = val1;
    assign shamt     = val2[4:0];

    always_comb begin
        alu_out = '0;
        case (EXE_CMD)
            EXE_ADD: alu_out = val1 + val2;
            EXE_SUB: alu_out = val1 - val2;
            EXE_AND: alu_out = val1 & val2;
            EXE_OR:  alu_out = val1 | val2;
            EXE_NOR: alu_out = ~(val1 | val2);
            EXE_XOR: alu_out = val1 ^ val2;
            EXE_SLL: alu_out = val1 << shamt;
            EXE_SRL: alu_out = val1 >> shamt;
            EXE_SRA: alu_out = WORD_LEN'(val1_s >>> shamt);
            EXE_DIV: alu_out = '1;
            default: alu_out = '0;
        endcase
    end

    exe_stage_muldiv_iter #(.W(WORD_LEN)) u_iter (
        .clk    (clk),
        .rst    (rst),
        .abort  (flush),
        .start  (eng_start),
        .op     (EXE_CMD == EXE_DIV),
        .a      (val1),
        .b      (val2),
        .busy   (eng_busy),
        .done   (eng_done),
        .result (eng_result)
    );

    always_ff @(posedge clk) begin
        if (eng_start) begin
            hold_st    <= ST_val_in;
            hold_dest  <= dest_in;
            hold_mem_r <= MEM_R_EN_in;
            hold_mem_w <= MEM_W_EN_in;
            hold_wb    <= WB_EN_in;
        end
    end

    // EXE/MEM register boundary
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            out_valid <= 1'b0;
            ALU_res   <= '0;
            ST_value  <= '0;
            dest      <= '0;
            MEM_R_EN  <= 1'b0;
            MEM_W_EN  <= 1'b0;
            WB_EN     <= 1'b0;
        end else if (flush) begin
            state     <= ST_IDLE;
            out_valid <= 1'b0;
            MEM_R_EN  <= 1'b0;
            MEM_W_EN  <= 1'b0;
            WB_EN     <= 1'b0;
        end else if (state == ST_BUSY) begin
            if (eng_done) begin
                state     <= ST_IDLE;
                out_valid <= 1'b1;
                ALU_res   <= eng_result;
                ST_value  <= hold_st;
                dest      <= hold_dest;
                MEM_R_EN  <= hold_mem_r;
                MEM_W_EN  <= hold_mem_w;
                WB_EN     <= hold_wb;
            end else begin
                if (!eng_busy) begin
                    state <= ST_IDLE;
                end
                out_valid <= 1'b0;
                MEM_R_EN  <= 1'b0;
                MEM_W_EN  <= 1'b0;
                WB_EN     <= 1'b0;
            end
        end else if (accept && !is_multi) begin
            out_valid <= 1'b1;
            ALU_res   <= alu_out;
            ST_value  <= ST_val_in;
            dest      <= dest_in;
            MEM_R_EN  <= MEM_R_EN_in;
            MEM_W_EN  <= MEM_W_EN_in;
            WB_EN     <= WB_EN_in;
        end else begin
            if (accept) begin
                state <= ST_BUSY;
            end
            out_valid <= 1'b0;
            MEM_R_EN  <= 1'b0;
            MEM_W_EN  <= 1'b0;
            WB_EN     <= 1'b0;
        end
    end

endmodule
